// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types for the MAC lane sequencer.
// Optional build macro: MAC_SEQ_STALL_CNT_EN (enables the stall counter).
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    RESULT
  } mac_seq_state_e;

  function automatic int acc_width(input int dw);
    return 3 * dw;
  endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Operand stream, lane control and result handshake bundle.
// Optional build macro: MAC_SEQ_STALL_CNT_EN (no effect on this file).
interface mac_seq_if
  import mac_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 8
) ();

  localparam int ACC_W = acc_width(DATA_WIDTH);

  logic                       op_valid;
  logic                       op_ready;
  logic                       mac_clr;
  logic                       mac_en;
  logic [NUM_LANES*ACC_W-1:0] mac_cout;
  logic                       res_valid;
  logic                       res_ready;
  logic [NUM_LANES*ACC_W-1:0] res_data;

  modport master (
    input  op_valid,
    input  mac_cout,
    input  res_ready,
    output op_ready,
    output mac_clr,
    output mac_en,
    output res_valid,
    output res_data
  );

  modport slave (
    output op_valid,
    output mac_cout,
    output res_ready,
    input  op_ready,
    input  mac_clr,
    input  mac_en,
    input  res_valid,
    input  res_data
  );

endinterface

// File: rtl/mac_seq_ctrl_beat_counter.sv
// Loadable up-counter: wraps after len beats, or saturates in SAT mode.
// Optional build macro: MAC_SEQ_STALL_CNT_EN (instantiated twice when set).
module mac_beat_counter #(
  parameter int W   = 9,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] len_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] len_q;
  logic         last;

  // SAT mode: last means the count is pinned at all-ones
  assign last = SAT ? (&cnt_q)
                    : (cnt_q == (len_q - W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      if (last)
        cnt_d = SAT ? cnt_q : '0;
      else
        cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      len_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
      len_q <= len_i;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = last;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for a lockstep bank of MAC lanes.
// Optional build macro: MAC_SEQ_STALL_CNT_EN (stall cycle counter).
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 8,
  parameter int MAX_LEN    = 256,
  localparam int LEN_W     = $clog2(MAX_LEN + 1),
  localparam int ACC_W     = acc_width(DATA_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  output logic             busy,
  output logic             len_err,
  mac_seq_if.master        bus,
  output logic [15:0]      stall_cnt
);

  mac_seq_state_e state_q;

  logic busy_q;
  logic len_err_q;
  logic op_ready_q;
  logic mac_clr_q;
  logic res_valid_q;
  logic [NUM_LANES*ACC_W-1:0] res_data_q;

  logic len_ok;
  logic accept;
  logic mac_en;
  logic beat_last;
  logic [LEN_W-1:0] unused_beat_cnt;

  assign len_ok = (vec_len != '0)
                & (vec_len <= LEN_W'(MAX_LEN));
  assign accept = (state_q == IDLE)
                & start & len_ok;
  assign mac_en = bus.op_valid & op_ready_q;

  mac_beat_counter #(
    .W   (LEN_W),
    .SAT (1'b0)
  ) u_beat (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .len_i  (vec_len),
    .inc_i  (mac_en),
    .cnt_o  (unused_beat_cnt),
    .last_o (beat_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      len_err_q   <= 1'b0;
      op_ready_q  <= 1'b0;
      mac_clr_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      len_err_q <= 1'b0;
      mac_clr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            start & len_ok: begin
              state_q   <= CLEAR;
              busy_q    <= 1'b1;
              mac_clr_q <= 1'b1;
            end
            start & ~len_ok: len_err_q <= 1'b1;
            default: ;
          endcase
        end
        CLEAR: begin
          state_q    <= STREAM;
          op_ready_q <= 1'b1;
        end
        STREAM: begin
          if (mac_en && beat_last) begin
            state_q    <= DRAIN;
            op_ready_q <= 1'b0;
          end
        end
        DRAIN: begin
          // lanes now hold the final sums
          res_data_q  <= bus.mac_cout;
          res_valid_q <= 1'b1;
          state_q     <= RESULT;
        end
        RESULT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign len_err       = len_err_q;
  assign bus.op_ready  = op_ready_q;
  assign bus.mac_clr   = mac_clr_q;
  assign bus.mac_en    = mac_en;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

`ifdef MAC_SEQ_STALL_CNT_EN
  logic stall_inc;
  logic unused_stall_sat;

  assign stall_inc = (state_q == STREAM)
                   & ~bus.op_valid;

  mac_beat_counter #(
    .W   (16),
    .SAT (1'b1)
  ) u_stall (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .len_i  (16'h0000),
    .inc_i  (stall_inc),
    .cnt_o  (stall_cnt),
    .last_o (unused_stall_sat)
  );
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl with a behavioural MAC lane bank.
// Optional build macro: MAC_SEQ_STALL_CNT_EN (changes stall expectation).
module tb_mac_seq_ctrl;
  import mac_ctrl_pkg::*;

  localparam int DW = 8;
  localparam int NL = 8;
  localparam int ML = 256;
  localparam int LW = $clog2(ML + 1);
  localparam int AW = 3 * DW;

  typedef logic [NL*AW-1:0] word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] vec_len;
  logic          busy;
  logic          len_err;
  logic [15:0]   stall_cnt;

  mac_seq_if #(.DATA_WIDTH(DW), .NUM_LANES(NL)) bus ();

  mac_seq_ctrl #(
    .DATA_WIDTH (DW),
    .NUM_LANES  (NL),
    .MAX_LEN    (ML)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vec_len   (vec_len),
    .busy      (busy),
    .len_err   (len_err),
    .bus       (bus.master),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] opa [NL];
  logic [DW-1:0] opb [NL];
  logic [AW-1:0] acc [NL];

  always @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (rst || bus.mac_clr)
        acc[i] <= '0;
      else if (bus.mac_en)
        acc[i] <= acc[i] + AW'(opa[i]) * AW'(opb[i]);
    end
  end

  always_comb begin
    bus.mac_cout = '0;
    for (int i = 0; i < NL; i++)
      bus.mac_cout[i*AW +: AW] = acc[i];
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  word_t sb[$];
  int    en_cnt = 0;
  int    clr_cnt = 0;
  int    clr_cyc = 0;
  int    rv_cyc = 0;
  int    pops = 0;
  logic  rv_prev = 1'b0;

  always @(negedge clk) begin
    word_t ew;
    if (bus.mac_clr) begin
      clr_cnt++;
      clr_cyc = cyc;
    end
    if (bus.mac_en) en_cnt++;
    if (bus.mac_clr && bus.mac_en)
      chk("clr_en_excl", 1, 0);
    if (bus.res_valid && !rv_prev) rv_cyc = cyc;
    rv_prev = bus.res_valid;
    if (bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        ew = sb.pop_front();
        pops++;
        for (int i = 0; i < NL; i++)
          chk($sformatf("res_lane%0d", i),
              64'(bus.res_data[i*AW +: AW]),
              64'(ew[i*AW +: AW]));
      end
    end
  end

  function automatic logic [7:0] av(
      int l, int k, logic [7:0] b, bit vary);
    return vary ? 8'(int'(b) + l + k) : b;
  endfunction

  function automatic logic [7:0] bv(
      int l, int k, logic [7:0] b, bit vary);
    return vary ? 8'(int'(b) + 3*l + 2*k) : b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int t0;

  task automatic run_job(input int len,
                         input logic [15:0] pat,
                         input int patlen,
                         input logic [7:0] ab,
                         input logic [7:0] bb,
                         input bit vary,
                         output word_t w);
    logic [AW-1:0] s;
    int k, j;
    bit v;
    w = '0;
    for (int l = 0; l < NL; l++) begin
      s = '0;
      for (int b = 0; b < len; b++)
        s = s + AW'(av(l, b, ab, vary))
              * AW'(bv(l, b, bb, vary));
      w[l*AW +: AW] = s;
    end
    sb.push_back(w);
    t0 = cyc;
    start = 1'b1;
    vec_len = LW'(len);
    tick();
    start = 1'b0;
    bus.op_valid = 1'b0;
    tick();
    k = 0;
    j = 0;
    while (k < len && j < len + 100) begin
      v = (j < patlen) ? pat[j] : 1'b1;
      bus.op_valid = v;
      for (int l = 0; l < NL; l++) begin
        opa[l] = av(l, k, ab, vary);
        opb[l] = bv(l, k, bb, vary);
      end
      tick();
      if (v) k++;
      j++;
    end
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_result(input int budget);
    int n = 0;
    while (!bus.res_valid && n < budget) begin
      tick();
      n++;
    end
    chk("res_wait", 64'(bus.res_valid), 1);
    if (bus.res_ready) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    word_t w;
    int en0, clr0, exp_stall;
    rst = 1'b1;
    start = 1'b0;
    vec_len = '0;
    bus.op_valid = 1'b0;
    bus.res_ready = 1'b1;
    for (int l = 0; l < NL; l++) begin
      opa[l] = '0;
      opb[l] = '0;
    end
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_len_err", 64'(len_err), 0);
    chk("rst_op_ready", 64'(bus.op_ready), 0);
    chk("rst_mac_clr", 64'(bus.mac_clr), 0);
    chk("rst_res_valid", 64'(bus.res_valid), 0);
    chk("rst_res_data", 64'(|bus.res_data), 0);
    chk("rst_stall", 64'(stall_cnt), 0);
    rst = 1'b0;
    tick();

    // 1: four beats of 3*5 per lane
    en0 = en_cnt;
    run_job(4, '0, 0, 8'd3, 8'd5, 1'b0, w);
    wait_result(10);
    chk("t1_clr_cyc", 64'(clr_cyc), 64'(t0 + 1));
    chk("t1_rv_cyc", 64'(rv_cyc), 64'(t0 + 7));
    chk("t1_en_pulses", 64'(en_cnt - en0), 4);
    chk("t1_lane0", 64'(bus.res_data[AW-1:0]), 60);
    chk("t1_idle", 64'(busy), 0);

    // 2: stalls in the stream
    en0 = en_cnt;
    run_job(3, 16'b10_1001, 6, 8'd10, 8'd20,
            1'b1, w);
    wait_result(10);
    chk("t2_en_pulses", 64'(en_cnt - en0), 3);
`ifdef MAC_SEQ_STALL_CNT_EN
    exp_stall = 3;
`else
    exp_stall = 0;
`endif
    chk("t2_stall_cnt", 64'(stall_cnt),
        64'(exp_stall));

    // 3: illegal lengths
    clr0 = clr_cnt;
    start = 1'b1;
    vec_len = '0;
    tick();
    start = 1'b0;
    chk("t3_err0", 64'(len_err), 1);
    chk("t3_busy0", 64'(busy), 0);
    tick();
    chk("t3_err0_pulse", 64'(len_err), 0);
    start = 1'b1;
    vec_len = LW'(ML + 1);
    tick();
    start = 1'b0;
    chk("t3_err_max", 64'(len_err), 1);
    chk("t3_busy_max", 64'(busy), 0);
    tick();
    chk("t3_err_max_pulse", 64'(len_err), 0);
    tick();
    chk("t3_no_clr", 64'(clr_cnt), 64'(clr0));

    // 4: back-pressured result, start ignored
    bus.res_ready = 1'b0;
    run_job(3, '0, 0, 8'd40, 8'd7, 1'b1, w);
    wait_result(10);
    for (int i = 0; i < 5; i++) begin
      start = (i == 1 || i == 2);
      vec_len = LW'(2);
      tick();
      chk("t4_hold_l0",
          64'(bus.res_data[AW-1:0]),
          64'(w[AW-1:0]));
      chk("t4_hold_l7",
          64'(bus.res_data[7*AW +: AW]),
          64'(w[7*AW +: AW]));
      chk("t4_busy", 64'(busy), 1);
    end
    start = 1'b0;
    clr0 = clr_cnt;
    bus.res_ready = 1'b1;
    tick();
    chk("t4_idle", 64'(busy), 0);
    chk("t4_rv_low", 64'(bus.res_valid), 0);
    tick();
    tick();
    chk("t4_start_ignored", 64'(clr_cnt),
        64'(clr0));

    // 5: reset mid-stream after two beats
    start = 1'b1;
    vec_len = LW'(8);
    tick();
    start = 1'b0;
    tick();
    bus.op_valid = 1'b1;
    for (int l = 0; l < NL; l++) begin
      opa[l] = 8'd7;
      opb[l] = 8'd9;
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t5_busy", 64'(busy), 0);
    chk("t5_op_ready", 64'(bus.op_ready), 0);
    chk("t5_mac_en", 64'(bus.mac_en), 0);
    chk("t5_mac_clr", 64'(bus.mac_clr), 0);
    chk("t5_res_valid", 64'(bus.res_valid), 0);
    chk("t5_res_data", 64'(|bus.res_data), 0);
    rst = 1'b0;
    bus.op_valid = 1'b0;
    tick();
    run_job(2, '0, 0, 8'd2, 8'd11, 1'b1, w);
    wait_result(10);

    // 6: full-length job, no 24-bit wrap
    run_job(ML, '0, 0, 8'hFF, 8'hFF, 1'b0, w);
    wait_result(10);
    chk("t6_lane7",
        64'(bus.res_data[7*AW +: AW]),
        64'd16646400);

    tick();
    chk("sb_drained", 64'(sb.size()), 0);
    chk("result_count", 64'(pops), 5);
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
